// File: rtl/axi_mem_window.sv
// axi_mem_window: AXI4 address-window bridge between the Rocket memory master
// and the PS HP slave port. In-window requests are rebased onto WIN_BASE and
// forwarded; out-of-window requests are answered locally with DECERR once all
// forwarded traffic in that direction has drained, so responses stay ordered.
// Optional build macro AXI_MEM_WINDOW_STATS_EN adds four saturating
// forwarded/rejected request counters.
//
// state   | meaning
// WE_IDLE | no rejected write pending
// WE_WAIT | rejected AW taken; waiting for its W burst to drain and wr_out==0
// WE_RESP | presenting DECERR on s_b until accepted
// RE_IDLE | no rejected read pending
// RE_WAIT | rejected AR taken; waiting for rd_out==0
// RE_SEND | emitting len+1 DECERR beats on s_r
module axi_mem_window #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W = 6,
  parameter int WIN_LOG2 = 28,
  parameter logic [ADDR_W-1:0] WIN_BASE = ADDR_W'(32'h1000_0000),
  parameter int MAX_OUT = 8
) (
  input  logic                clock,
  input  logic                reset_n,
`ifdef AXI_MEM_WINDOW_STATS_EN
  output logic [31:0]         stat_wr_fwd,
  output logic [31:0]         stat_rd_fwd,
  output logic [31:0]         stat_wr_err,
  output logic [31:0]         stat_rd_err,
`endif
  input  logic                s_aw_valid,
  output logic                s_aw_ready,
  input  logic [ADDR_W-1:0]   s_aw_addr,
  input  logic [ID_W-1:0]     s_aw_id,
  input  logic [7:0]          s_aw_len,
  input  logic [2:0]          s_aw_size,
  input  logic [1:0]          s_aw_burst,
  input  logic [3:0]          s_aw_cache,
  input  logic [2:0]          s_aw_prot,
  input  logic [3:0]          s_aw_qos,
  input  logic                s_aw_lock,
  input  logic                s_w_valid,
  output logic                s_w_ready,
  input  logic [DATA_W-1:0]   s_w_data,
  input  logic [DATA_W/8-1:0] s_w_strb,
  input  logic                s_w_last,
  output logic                s_b_valid,
  input  logic                s_b_ready,
  output logic [ID_W-1:0]     s_b_id,
  output logic [1:0]          s_b_resp,
  input  logic                s_ar_valid,
  output logic                s_ar_ready,
  input  logic [ADDR_W-1:0]   s_ar_addr,
  input  logic [ID_W-1:0]     s_ar_id,
  input  logic [7:0]          s_ar_len,
  input  logic [2:0]          s_ar_size,
  input  logic [1:0]          s_ar_burst,
  input  logic [3:0]          s_ar_cache,
  input  logic [2:0]          s_ar_prot,
  input  logic [3:0]          s_ar_qos,
  input  logic                s_ar_lock,
  output logic                s_r_valid,
  input  logic                s_r_ready,
  output logic [ID_W-1:0]     s_r_id,
  output logic [DATA_W-1:0]   s_r_data,
  output logic [1:0]          s_r_resp,
  output logic                s_r_last,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [ID_W-1:0]     m_aw_id,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic [3:0]          m_aw_cache,
  output logic [2:0]          m_aw_prot,
  output logic [3:0]          m_aw_qos,
  output logic                m_aw_lock,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [ID_W-1:0]     m_b_id,
  input  logic [1:0]          m_b_resp,
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [ID_W-1:0]     m_ar_id,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  output logic [3:0]          m_ar_cache,
  output logic [2:0]          m_ar_prot,
  output logic [3:0]          m_ar_qos,
  output logic                m_ar_lock,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [ID_W-1:0]     m_r_id,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic              lock;
  } ax_t;

  typedef enum logic [1:0] {WE_IDLE, WE_WAIT, WE_RESP} we_t;
  typedef enum logic [1:0] {RE_IDLE, RE_WAIT, RE_SEND} re_t;

  ax_t aw_q, ar_q;
  logic aw_full, ar_full, ready_en;
  logic [CNT_W-1:0] wr_out, rd_out, wf_cnt;
  logic [PTR_W-1:0] wf_wr, wf_rd;
  logic [MAX_OUT-1:0] wf_mem;
  we_t we_state;
  re_t re_state;
  logic [ID_W-1:0] we_id, re_id;
  logic [7:0] re_len, re_cnt;

  logic aw_hit, ar_hit, aw_fwd_hs, ar_fwd_hs, aw_err_take, ar_err_take;
  logic wf_full, w_fwd, w_err, w_pop, b_hs, r_last_hs, we_resp, re_send;

  assign aw_hit = (aw_q.addr[ADDR_W-1:WIN_LOG2] == '0);
  assign ar_hit = (ar_q.addr[ADDR_W-1:WIN_LOG2] == '0);
  assign wf_full = (wf_cnt == CNT_W'(MAX_OUT));
  assign we_resp = (we_state == WE_RESP);
  assign re_send = (re_state == RE_SEND);

  // Readies stay low in reset and for one cycle after release.
  assign s_aw_ready = ready_en && !aw_full;
  assign s_ar_ready = ready_en && !ar_full;

  assign m_aw_valid = aw_full && aw_hit && (we_state == WE_IDLE) && !wf_full
                      && (wr_out != CNT_W'(MAX_OUT));
  assign aw_err_take = aw_full && !aw_hit && (we_state == WE_IDLE) && !wf_full;
  assign aw_fwd_hs = m_aw_valid && m_aw_ready;
  assign m_ar_valid = ar_full && ar_hit && (re_state == RE_IDLE)
                      && (rd_out != CNT_W'(MAX_OUT));
  assign ar_err_take = ar_full && !ar_hit && (re_state == RE_IDLE);
  assign ar_fwd_hs = m_ar_valid && m_ar_ready;

  // Address is gated so an empty slice shows 0 rather than WIN_BASE.
  assign m_aw_addr  = aw_full ? aw_q.addr + WIN_BASE : '0;
  assign m_aw_id    = aw_q.id;
  assign m_aw_len   = aw_q.len;
  assign m_aw_size  = aw_q.size;
  assign m_aw_burst = aw_q.burst;
  assign m_aw_cache = aw_q.cache;
  assign m_aw_prot  = aw_q.prot;
  assign m_aw_qos   = aw_q.qos;
  assign m_aw_lock  = aw_q.lock;
  assign m_ar_addr  = ar_full ? ar_q.addr + WIN_BASE : '0;
  assign m_ar_id    = ar_q.id;
  assign m_ar_len   = ar_q.len;
  assign m_ar_size  = ar_q.size;
  assign m_ar_burst = ar_q.burst;
  assign m_ar_cache = ar_q.cache;
  assign m_ar_prot  = ar_q.prot;
  assign m_ar_qos   = ar_q.qos;
  assign m_ar_lock  = ar_q.lock;

  // W routing follows the head of the route FIFO: forward or swallow.
  assign w_fwd = (wf_cnt != '0) && wf_mem[wf_rd];
  assign w_err = (wf_cnt != '0) && !wf_mem[wf_rd];
  assign s_w_ready = w_fwd ? m_w_ready : w_err;
  assign m_w_valid = w_fwd && s_w_valid;
  assign m_w_data  = w_fwd ? s_w_data : '0;
  assign m_w_strb  = w_fwd ? s_w_strb : '0;
  assign m_w_last  = w_fwd && s_w_last;
  assign w_pop = s_w_valid && s_w_ready && s_w_last;

  assign s_b_valid = we_resp || m_b_valid;
  assign s_b_id    = we_resp ? we_id : (m_b_valid ? m_b_id : '0);
  assign s_b_resp  = we_resp ? 2'b11 : (m_b_valid ? m_b_resp : 2'b00);
  assign m_b_ready = !we_resp && s_b_ready;
  assign b_hs = m_b_valid && m_b_ready;

  assign s_r_valid = re_send || m_r_valid;
  assign s_r_id    = re_send ? re_id : (m_r_valid ? m_r_id : '0);
  assign s_r_data  = (!re_send && m_r_valid) ? m_r_data : '0;
  assign s_r_resp  = re_send ? 2'b11 : (m_r_valid ? m_r_resp : 2'b00);
  assign s_r_last  = re_send ? (re_cnt == re_len) : (m_r_valid && m_r_last);
  assign m_r_ready = !re_send && s_r_ready;
  assign r_last_hs = m_r_valid && m_r_ready && m_r_last;

  // Request slices: capture when empty, release on forward or rejection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
      aw_full <= 1'b0;
      ar_full <= 1'b0;
      aw_q <= '0;
      ar_q <= '0;
    end else begin
      ready_en <= 1'b1;
      if (s_aw_valid && s_aw_ready) begin
        aw_full <= 1'b1;
        aw_q <= {s_aw_addr, s_aw_id, s_aw_len, s_aw_size, s_aw_burst,
                 s_aw_cache, s_aw_prot, s_aw_qos, s_aw_lock};
      end else if (aw_fwd_hs || aw_err_take) begin
        aw_full <= 1'b0;
      end
      if (s_ar_valid && s_ar_ready) begin
        ar_full <= 1'b1;
        ar_q <= {s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst,
                 s_ar_cache, s_ar_prot, s_ar_qos, s_ar_lock};
      end else if (ar_fwd_hs || ar_err_take) begin
        ar_full <= 1'b0;
      end
    end
  end

  // Outstanding forwarded transaction counters per direction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_out <= '0;
      rd_out <= '0;
    end else begin
      if (aw_fwd_hs && !b_hs) wr_out <= wr_out + 1'b1;
      else if (!aw_fwd_hs && b_hs) wr_out <= wr_out - 1'b1;
      if (ar_fwd_hs && !r_last_hs) rd_out <= rd_out + 1'b1;
      else if (!ar_fwd_hs && r_last_hs) rd_out <= rd_out - 1'b1;
    end
  end

  // W-route FIFO: one bit per accepted AW (1 = forward, 0 = discard).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wf_mem <= '0;
      wf_wr <= '0;
      wf_rd <= '0;
      wf_cnt <= '0;
    end else begin
      if (aw_fwd_hs || aw_err_take) begin
        wf_mem[wf_wr] <= aw_fwd_hs;
        wf_wr <= wf_wr + 1'b1;
      end
      if (w_pop) wf_rd <= wf_rd + 1'b1;
      if ((aw_fwd_hs || aw_err_take) && !w_pop) wf_cnt <= wf_cnt + 1'b1;
      else if (!(aw_fwd_hs || aw_err_take) && w_pop) wf_cnt <= wf_cnt - 1'b1;
    end
  end

  // Write error FSM: DECERR only after all earlier writes have completed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_state <= WE_IDLE;
      we_id <= '0;
    end else begin
      case (we_state)
        WE_IDLE: if (aw_err_take) begin
          we_id <= aw_q.id;
          we_state <= WE_WAIT;
        end
        WE_WAIT: if (wf_cnt == '0 && wr_out == '0) we_state <= WE_RESP;
        WE_RESP: if (s_b_ready) we_state <= WE_IDLE;
        default: we_state <= WE_IDLE;
      endcase
    end
  end

  // Read error FSM: len+1 zero-data DECERR beats after forwarded reads drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      re_state <= RE_IDLE;
      re_id <= '0;
      re_len <= '0;
      re_cnt <= '0;
    end else begin
      case (re_state)
        RE_IDLE: if (ar_err_take) begin
          re_id <= ar_q.id;
          re_len <= ar_q.len;
          re_state <= RE_WAIT;
        end
        RE_WAIT: if (rd_out == '0) begin
          re_cnt <= '0;
          re_state <= RE_SEND;
        end
        RE_SEND: if (s_r_ready) begin
          if (re_cnt == re_len) re_state <= RE_IDLE;
          else re_cnt <= re_cnt + 1'b1;
        end
        default: re_state <= RE_IDLE;
      endcase
    end
  end

`ifdef AXI_MEM_WINDOW_STATS_EN
  // Saturating request statistics.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_wr_fwd <= '0;
      stat_rd_fwd <= '0;
      stat_wr_err <= '0;
      stat_rd_err <= '0;
    end else begin
      if (aw_fwd_hs && stat_wr_fwd != '1) stat_wr_fwd <= stat_wr_fwd + 1'b1;
      if (ar_fwd_hs && stat_rd_fwd != '1) stat_rd_fwd <= stat_rd_fwd + 1'b1;
      if (aw_err_take && stat_wr_err != '1) stat_wr_err <= stat_wr_err + 1'b1;
      if (ar_err_take && stat_rd_err != '1) stat_rd_err <= stat_rd_err + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_mem_window.sv
// Scoreboard bench for axi_mem_window: master/slave BFMs with random
// handshakes, expectations queued at request acceptance, monitors pop/compare.
module tb_axi_mem_window;
  localparam int AW = 32, DW = 64, IW = 6, WL = 28;
  localparam logic [31:0] WB = 32'h1000_0000;

  logic clock, reset_n;
  logic s_aw_valid, s_aw_ready, s_aw_lock, s_ar_valid, s_ar_ready, s_ar_lock;
  logic [AW-1:0] s_aw_addr, s_ar_addr, m_aw_addr, m_ar_addr;
  logic [IW-1:0] s_aw_id, s_ar_id, s_b_id, s_r_id, m_aw_id, m_ar_id, m_b_id, m_r_id;
  logic [7:0] s_aw_len, s_ar_len, m_aw_len, m_ar_len;
  logic [2:0] s_aw_size, s_ar_size, m_aw_size, m_ar_size, s_aw_prot, s_ar_prot, m_aw_prot, m_ar_prot;
  logic [1:0] s_aw_burst, s_ar_burst, m_aw_burst, m_ar_burst, s_b_resp, s_r_resp, m_b_resp, m_r_resp;
  logic [3:0] s_aw_cache, s_ar_cache, m_aw_cache, m_ar_cache, s_aw_qos, s_ar_qos, m_aw_qos, m_ar_qos;
  logic m_aw_lock, m_ar_lock, m_aw_valid, m_aw_ready, m_ar_valid, m_ar_ready;
  logic s_w_valid, s_w_ready, s_w_last, m_w_valid, m_w_ready, m_w_last;
  logic [DW-1:0] s_w_data, m_w_data, s_r_data, m_r_data;
  logic [DW/8-1:0] s_w_strb, m_w_strb;
  logic s_b_valid, s_b_ready, m_b_valid, m_b_ready;
  logic s_r_valid, s_r_ready, s_r_last, m_r_valid, m_r_ready, m_r_last;
`ifdef AXI_MEM_WINDOW_STATS_EN
  logic [31:0] stat_wr_fwd, stat_rd_fwd, stat_wr_err, stat_rd_err;
`endif

  axi_mem_window dut (
    .clock(clock), .reset_n(reset_n),
`ifdef AXI_MEM_WINDOW_STATS_EN
    .stat_wr_fwd(stat_wr_fwd), .stat_rd_fwd(stat_rd_fwd),
    .stat_wr_err(stat_wr_err), .stat_rd_err(stat_rd_err),
`endif
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_cache(s_aw_cache),
    .s_aw_prot(s_aw_prot), .s_aw_qos(s_aw_qos), .s_aw_lock(s_aw_lock),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_cache(s_ar_cache),
    .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos), .s_ar_lock(s_ar_lock),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id), .s_r_data(s_r_data),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_cache(m_aw_cache),
    .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos), .m_aw_lock(m_aw_lock),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_cache(m_ar_cache),
    .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos), .m_ar_lock(m_ar_lock),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_data(m_r_data),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr; logic [5:0] id; logic [7:0] len; logic [16:0] attr;
    logic [7:0][63:0] data; logic [7:0][7:0] strb;
  } req_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } wbeat_t;
  typedef struct { logic [5:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;

  req_t ar_todo[$], aw_todo[$], exp_m_ar[$], exp_m_aw[$], slv_rd[$];
  wbeat_t w_todo[$], exp_m_w[$];
  rbeat_t exp_s_r[$];
  logic [7:0] exp_s_b[$];
  logic [5:0] slv_aw_ids[$], slv_b[$];
  int n_chk = 0, n_fail = 0;
  int n_rd_hit = 0, n_rd_miss = 0, n_wr_hit = 0, n_wr_miss = 0;
  bit hold_r = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic spurious(input string name);
    n_chk++; n_fail++;
    $display("FAIL %s: unexpected transfer, expected none (t=%0t)", name, $time);
  endtask

  // Reference rules: window is [0, 2^WL); forwarded address is WIN_BASE+addr mod 2^32.
  function automatic bit in_window(input logic [31:0] a);
    return longint'(a) < (longint'(1) << WL);
  endfunction
  function automatic logic [31:0] fwd_addr(input logic [31:0] a);
    return 32'((longint'(WB) + longint'(a)) % (longint'(1) << 32));
  endfunction
  function automatic logic [63:0] mem_data(input logic [31:0] a, input int beat);
    return {a, 24'h0, 8'(beat)};
  endfunction

  task automatic gen_rd(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len);
    req_t r;
    r.addr = addr; r.id = id; r.len = len; r.attr = 17'($urandom);
    r.data = '0; r.strb = '0;
    ar_todo.push_back(r);
  endtask

  task automatic gen_wr(input logic [31:0] addr, input logic [5:0] id, input logic [7:0] len, input bit full_strb);
    req_t r;
    wbeat_t w;
    r.addr = addr; r.id = id; r.len = len; r.attr = 17'($urandom);
    for (int b = 0; b < 8; b++) begin
      r.data[b] = {$urandom, $urandom};
      r.strb[b] = full_strb ? 8'hFF : 8'($urandom);
    end
    aw_todo.push_back(r);
    for (int b = 0; b <= int'(len); b++) begin
      w.data = r.data[b]; w.strb = r.strb[b]; w.last = (b == int'(len));
      w_todo.push_back(w);
    end
  endtask

  function automatic logic [31:0] rand_addr(input bit hit);
    logic [31:0] a;
    a = {4'h0, 28'($urandom) & 28'hFFF_FFF8};
    if (!hit) a[31:28] = 4'($urandom_range(15, 1));
    return a;
  endfunction

  // Rocket-side AR master; expectations are queued at acceptance.
  initial begin
    bit took = 0;
    s_ar_valid = 0; s_ar_addr = '0; s_ar_id = '0; s_ar_len = '0;
    {s_ar_size, s_ar_burst, s_ar_cache, s_ar_prot, s_ar_qos, s_ar_lock} = '0;
    forever begin
      @(negedge clock);
      if (took) begin s_ar_valid = 0; took = 0; end
      if (!reset_n || ar_todo.size() == 0) s_ar_valid = 0;
      else if (!s_ar_valid) s_ar_valid = ($urandom % 4) != 0;
      if (s_ar_valid) begin
        s_ar_addr = ar_todo[0].addr; s_ar_id = ar_todo[0].id; s_ar_len = ar_todo[0].len;
        {s_ar_size, s_ar_burst, s_ar_cache, s_ar_prot, s_ar_qos, s_ar_lock} = ar_todo[0].attr;
      end
      #1;
      if (s_ar_valid && s_ar_ready) begin
        req_t r;
        rbeat_t e;
        r = ar_todo.pop_front();
        took = 1;
        if (in_window(r.addr)) begin
          n_rd_hit++;
          r.addr = fwd_addr(r.addr);
          exp_m_ar.push_back(r);
          for (int b = 0; b <= int'(r.len); b++) begin
            e.id = r.id; e.data = mem_data(r.addr, b); e.resp = 2'b00; e.last = (b == int'(r.len));
            exp_s_r.push_back(e);
          end
        end else begin
          n_rd_miss++;
          for (int b = 0; b <= int'(r.len); b++) begin
            e.id = r.id; e.data = '0; e.resp = 2'b11; e.last = (b == int'(r.len));
            exp_s_r.push_back(e);
          end
        end
      end
    end
  end

  // Rocket-side AW master.
  initial begin
    bit took = 0;
    s_aw_valid = 0; s_aw_addr = '0; s_aw_id = '0; s_aw_len = '0;
    {s_aw_size, s_aw_burst, s_aw_cache, s_aw_prot, s_aw_qos, s_aw_lock} = '0;
    forever begin
      @(negedge clock);
      if (took) begin s_aw_valid = 0; took = 0; end
      if (!reset_n || aw_todo.size() == 0) s_aw_valid = 0;
      else if (!s_aw_valid) s_aw_valid = ($urandom % 4) != 0;
      if (s_aw_valid) begin
        s_aw_addr = aw_todo[0].addr; s_aw_id = aw_todo[0].id; s_aw_len = aw_todo[0].len;
        {s_aw_size, s_aw_burst, s_aw_cache, s_aw_prot, s_aw_qos, s_aw_lock} = aw_todo[0].attr;
      end
      #1;
      if (s_aw_valid && s_aw_ready) begin
        req_t r;
        wbeat_t w;
        r = aw_todo.pop_front();
        took = 1;
        if (in_window(r.addr)) begin
          n_wr_hit++;
          r.addr = fwd_addr(r.addr);
          exp_m_aw.push_back(r);
          for (int b = 0; b <= int'(r.len); b++) begin
            w.data = r.data[b]; w.strb = r.strb[b]; w.last = (b == int'(r.len));
            exp_m_w.push_back(w);
          end
          exp_s_b.push_back({2'b00, r.id});
        end else begin
          n_wr_miss++;
          exp_s_b.push_back({2'b11, r.id});
        end
      end
    end
  end

  // Rocket-side W master.
  initial begin
    bit took = 0;
    s_w_valid = 0; s_w_data = '0; s_w_strb = '0; s_w_last = 0;
    forever begin
      @(negedge clock);
      if (took) begin s_w_valid = 0; took = 0; end
      if (!reset_n || w_todo.size() == 0) s_w_valid = 0;
      else if (!s_w_valid) s_w_valid = ($urandom % 4) != 0;
      if (s_w_valid) begin
        s_w_data = w_todo[0].data; s_w_strb = w_todo[0].strb; s_w_last = w_todo[0].last;
      end
      #1;
      if (s_w_valid && s_w_ready) begin void'(w_todo.pop_front()); took = 1; end
    end
  end

  // PS-side AR slave and checker.
  initial begin
    m_ar_ready = 0;
    forever begin
      @(negedge clock);
      m_ar_ready = ($urandom % 4) != 0;
      #1;
      if (m_ar_valid && m_ar_ready) begin
        if (exp_m_ar.size() == 0) spurious("m_ar");
        else begin
          req_t e, g;
          e = exp_m_ar.pop_front();
          chk("m_ar_addr", 64'(m_ar_addr), 64'(e.addr));
          chk("m_ar_id", 64'(m_ar_id), 64'(e.id));
          chk("m_ar_len", 64'(m_ar_len), 64'(e.len));
          chk("m_ar_attr", 64'({m_ar_size, m_ar_burst, m_ar_cache, m_ar_prot, m_ar_qos, m_ar_lock}), 64'(e.attr));
          g = e; g.addr = m_ar_addr; g.id = m_ar_id; g.len = m_ar_len;
          slv_rd.push_back(g);
        end
      end
    end
  end

  // PS-side R slave: in-order read data derived from the received address.
  initial begin
    bit took = 0;
    int beat = 0;
    m_r_valid = 0; m_r_id = '0; m_r_data = '0; m_r_resp = '0; m_r_last = 0;
    forever begin
      @(negedge clock);
      if (took) begin m_r_valid = 0; took = 0; end
      if (!m_r_valid && slv_rd.size() > 0 && !hold_r) m_r_valid = ($urandom % 4) != 0;
      if (m_r_valid) begin
        m_r_id = slv_rd[0].id; m_r_data = mem_data(slv_rd[0].addr, beat);
        m_r_resp = 2'b00; m_r_last = (beat == int'(slv_rd[0].len));
      end
      #1;
      if (m_r_valid && m_r_ready) begin
        took = 1;
        if (m_r_last) begin void'(slv_rd.pop_front()); beat = 0; end
        else beat++;
      end
    end
  end

  // PS-side AW slave and checker.
  initial begin
    m_aw_ready = 0;
    forever begin
      @(negedge clock);
      m_aw_ready = ($urandom % 4) != 0;
      #1;
      if (m_aw_valid && m_aw_ready) begin
        if (exp_m_aw.size() == 0) spurious("m_aw");
        else begin
          req_t e;
          e = exp_m_aw.pop_front();
          chk("m_aw_addr", 64'(m_aw_addr), 64'(e.addr));
          chk("m_aw_id", 64'(m_aw_id), 64'(e.id));
          chk("m_aw_len", 64'(m_aw_len), 64'(e.len));
          chk("m_aw_attr", 64'({m_aw_size, m_aw_burst, m_aw_cache, m_aw_prot, m_aw_qos, m_aw_lock}), 64'(e.attr));
        end
        slv_aw_ids.push_back(m_aw_id);
      end
    end
  end

  // PS-side W slave and checker; B is scheduled after a burst's last beat.
  initial begin
    m_w_ready = 0;
    forever begin
      @(negedge clock);
      m_w_ready = ($urandom % 4) != 0;
      #1;
      if (m_w_valid && m_w_ready) begin
        if (exp_m_w.size() == 0) spurious("m_w");
        else begin
          wbeat_t e;
          e = exp_m_w.pop_front();
          chk("m_w_data", m_w_data, e.data);
          chk("m_w_strb", 64'(m_w_strb), 64'(e.strb));
          chk("m_w_last", 64'(m_w_last), 64'(e.last));
        end
        if (m_w_last) begin
          if (slv_aw_ids.size() == 0) spurious("m_w_before_aw");
          else slv_b.push_back(slv_aw_ids.pop_front());
        end
      end
    end
  end

  // PS-side B slave.
  initial begin
    bit took = 0;
    m_b_valid = 0; m_b_id = '0; m_b_resp = '0;
    forever begin
      @(negedge clock);
      if (took) begin m_b_valid = 0; took = 0; end
      if (!m_b_valid && slv_b.size() > 0) m_b_valid = ($urandom % 4) != 0;
      if (m_b_valid) begin m_b_id = slv_b[0]; m_b_resp = 2'b00; end
      #1;
      if (m_b_valid && m_b_ready) begin void'(slv_b.pop_front()); took = 1; end
    end
  end

  // Rocket-side R monitor.
  initial begin
    s_r_ready = 0;
    forever begin
      @(negedge clock);
      s_r_ready = ($urandom % 4) != 0;
      #1;
      if (s_r_valid && s_r_ready) begin
        if (exp_s_r.size() == 0) spurious("s_r");
        else begin
          rbeat_t e;
          e = exp_s_r.pop_front();
          chk("s_r_id", 64'(s_r_id), 64'(e.id));
          chk("s_r_data", s_r_data, e.data);
          chk("s_r_resp", 64'(s_r_resp), 64'(e.resp));
          chk("s_r_last", 64'(s_r_last), 64'(e.last));
        end
      end
    end
  end

  // Rocket-side B monitor.
  initial begin
    s_b_ready = 0;
    forever begin
      @(negedge clock);
      s_b_ready = ($urandom % 4) != 0;
      #1;
      if (s_b_valid && s_b_ready) begin
        if (exp_s_b.size() == 0) spurious("s_b");
        else begin
          logic [7:0] e;
          e = exp_s_b.pop_front();
          chk("s_b_id", 64'(s_b_id), 64'(e[5:0]));
          chk("s_b_resp", 64'(s_b_resp), 64'(e[7:6]));
        end
      end
    end
  end

  function automatic bit all_idle();
    return ar_todo.size() == 0 && aw_todo.size() == 0 && w_todo.size() == 0 &&
           exp_m_ar.size() == 0 && exp_m_aw.size() == 0 && exp_m_w.size() == 0 &&
           exp_s_r.size() == 0 && exp_s_b.size() == 0 && slv_rd.size() == 0 &&
           slv_b.size() == 0 && slv_aw_ids.size() == 0;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin @(negedge clock); n++; end
    repeat (3) @(negedge clock);
    chk({name, "_drained"}, 64'(all_idle()), 64'd1);
  endtask

  task automatic check_quiet_reset(input string tag);
    chk({tag, "_s_aw_ready"}, 64'(s_aw_ready), 0);
    chk({tag, "_s_ar_ready"}, 64'(s_ar_ready), 0);
    chk({tag, "_s_w_ready"}, 64'(s_w_ready), 0);
    chk({tag, "_m_aw_valid"}, 64'(m_aw_valid), 0);
    chk({tag, "_m_ar_valid"}, 64'(m_ar_valid), 0);
    chk({tag, "_m_w_valid"}, 64'(m_w_valid), 0);
    chk({tag, "_s_b_valid"}, 64'(s_b_valid), 0);
    chk({tag, "_s_r_valid"}, 64'(s_r_valid), 0);
    chk({tag, "_m_aw_addr"}, 64'(m_aw_addr), 0);
    chk({tag, "_m_ar_addr"}, 64'(m_ar_addr), 0);
`ifdef AXI_MEM_WINDOW_STATS_EN
    chk({tag, "_stat_wr_fwd"}, 64'(stat_wr_fwd), 0);
    chk({tag, "_stat_rd_fwd"}, 64'(stat_rd_fwd), 0);
    chk({tag, "_stat_wr_err"}, 64'(stat_wr_err), 0);
    chk({tag, "_stat_rd_err"}, 64'(stat_rd_err), 0);
`endif
  endtask

  initial begin
    int n;
    reset_n = 0;
    repeat (3) @(negedge clock);
    #2 check_quiet_reset("reset");
    @(negedge clock);
    reset_n = 1;

    // Read hit, write hit at the window top, write miss at the window edge.
    gen_rd(32'h0000_1000, 6'd5, 8'd3);
    wait_idle("read_hit", 2000);
    gen_wr(32'h0FFF_FFF8, 6'd9, 8'd0, 1'b1);
    wait_idle("write_hit", 2000);
    gen_wr(32'h1000_0000, 6'd3, 8'd1, 1'b0);
    wait_idle("write_miss", 2000);

    // Miss read queued behind a long forwarded read.
    gen_rd(32'h0000_2000, 6'd1, 8'd7);
    gen_rd(32'h2000_0000, 6'd2, 8'd2);
    wait_idle("read_miss_order", 2000);

    // Outstanding limit: eight reads forwarded, ninth parked in the slice.
    hold_r = 1;
    for (int i = 0; i < 9; i++) gen_rd(rand_addr(1'b1), 6'(i + 10), 8'd0);
    n = 0;
    while ((slv_rd.size() < 8 || ar_todo.size() != 0) && n < 500) begin @(negedge clock); n++; end
    repeat (20) @(negedge clock);
    #2;
    chk("bp_fwd_count", 64'(slv_rd.size()), 64'd8);
    chk("bp_s_ar_ready", 64'(s_ar_ready), 0);
    chk("bp_m_ar_valid", 64'(m_ar_valid), 0);
    chk("bp_ninth_accepted", 64'(ar_todo.size()), 0);
    hold_r = 0;
    wait_idle("backpressure", 3000);

    // Random mixed traffic, roughly a quarter outside the window.
    for (int i = 0; i < 80; i++) begin
      bit hit;
      hit = ($urandom % 4) != 0;
      if ($urandom % 2) gen_rd(rand_addr(hit), 6'($urandom), 8'($urandom_range(7, 0)));
      else gen_wr(rand_addr(hit), 6'($urandom), 8'($urandom_range(7, 0)), 1'b0);
      repeat ($urandom_range(3, 0)) @(negedge clock);
    end
    wait_idle("random", 30000);

`ifdef AXI_MEM_WINDOW_STATS_EN
    #2;
    chk("stat_wr_fwd", 64'(stat_wr_fwd), 64'(n_wr_hit));
    chk("stat_rd_fwd", 64'(stat_rd_fwd), 64'(n_rd_hit));
    chk("stat_wr_err", 64'(stat_wr_err), 64'(n_wr_miss));
    chk("stat_rd_err", 64'(stat_rd_err), 64'(n_rd_miss));
`endif

    @(negedge clock);
    reset_n = 0;
    #2 check_quiet_reset("rereset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
